// File: rtl/instr_buffer_if.sv
// Fetch/decode side bundle of the instruction buffer: push lane, pop lane and status.
// The master modport is the fetch/decode driver, the slave modport is the buffer itself.
interface instr_buffer_if #(
    parameter int PUSH_CHANNEL = 3,
    parameter int POP_CHANNEL  = 2,
    parameter int DATA_WIDTH   = 128
);
    logic                                 flush;
    logic                                 stall_push;
    logic                                 stall_pop;
    logic [PUSH_CHANNEL*DATA_WIDTH-1:0]   data_push;
    logic [$clog2(PUSH_CHANNEL+1)-1:0]    push_num;
    logic                                 full;
    logic                                 empty;
    logic [POP_CHANNEL*DATA_WIDTH-1:0]    data_pop;
    logic [POP_CHANNEL-1:0]               pop_valid;
    logic [$clog2(POP_CHANNEL+1)-1:0]     pop_num;

    modport master (
        output flush, stall_push, stall_pop, data_push, push_num, pop_num,
        input  full, empty, data_pop, pop_valid
    );

    modport slave (
        input  flush, stall_push, stall_pop, data_push, push_num, pop_num,
        output full, empty, data_pop, pop_valid
    );
endinterface

// File: rtl/instr_buffer.sv
// Multi-bank in-order instruction buffer between fetch and decode; entries interleave across banks.
// Define INSTR_BUFFER_BYPASS_EN to forward pushes straight to the pop lane while the buffer is empty.
module instr_buffer #(
    parameter int CHANNEL      = 4,
    parameter int PUSH_CHANNEL = 3,
    parameter int POP_CHANNEL  = 2,
    parameter int DEPTH        = 4,
    parameter int DATA_WIDTH   = 128
) (
    input  logic            clk,
    input  logic            rst,
    instr_buffer_if.slave   bus
);
    localparam int CAP   = CHANNEL * DEPTH;
    localparam int PW    = $clog2(CAP);
    localparam int CW    = PW + 1;
    localparam int XW    = CW + 1;
    localparam int BW    = $clog2(CHANNEL);
    localparam int RW    = $clog2(DEPTH);
    localparam int NSLOT = (CHANNEL > POP_CHANNEL) ? CHANNEL : POP_CHANNEL;

    typedef logic [XW-1:0] cnt_t;

    function automatic cnt_t min_cnt(input cnt_t a, input cnt_t b);
        return (a < b) ? a : b;
    endfunction

    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] mem [CHANNEL][DEPTH];

    logic push_en;
    logic pop_en;
    logic bypass;
    cnt_t push_req;
    cnt_t pop_req;
    cnt_t stored;
    cnt_t avail;
    cnt_t visible;
    cnt_t pop_acc;
    cnt_t free;
    cnt_t push_acc;

    logic [NSLOT*DATA_WIDTH-1:0]       push_flat;
    logic [POP_CHANNEL*DATA_WIDTH-1:0] pop_flat;
    logic [PW-1:0]                     rd_ptr   [POP_CHANNEL];
    logic [BW-1:0]                     wr_slot  [CHANNEL];
    logic [RW-1:0]                     wr_row   [CHANNEL];
    logic                              wr_en    [CHANNEL];
    logic [DATA_WIDTH-1:0]             wr_data  [CHANNEL];

`ifdef INSTR_BUFFER_BYPASS_EN
    assign bypass = (count == '0) && !bus.flush && !bus.stall_push;
`else
    assign bypass = 1'b0;
`endif

    // Zero-padded so every bank/slot index selects a legal lane.
    assign push_flat = (NSLOT*DATA_WIDTH)'(bus.data_push);

    always_comb begin
        push_en  = !rst && !bus.flush && !bus.stall_push;
        pop_en   = !rst && !bus.flush && !bus.stall_pop;
        push_req = push_en ? min_cnt(cnt_t'(bus.push_num), cnt_t'(PUSH_CHANNEL)) : '0;
        pop_req  = pop_en ? cnt_t'(bus.pop_num) : '0;
        stored   = cnt_t'(count);
        avail    = bypass ? push_req : stored;
        visible  = min_cnt(avail, cnt_t'(POP_CHANNEL));
        pop_acc  = min_cnt(pop_req, visible);
        // Slots released by this cycle's pop are already available to the push.
        free     = cnt_t'(CAP) - stored + pop_acc;
        push_acc = min_cnt(push_req, free);
    end

    always_comb begin
        pop_flat      = '0;
        bus.pop_valid = '0;
        for (int i = 0; i < POP_CHANNEL; i++) begin
            rd_ptr[i] = head + PW'(i);
            if (bypass) begin
                pop_flat[i*DATA_WIDTH +: DATA_WIDTH] = push_flat[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                pop_flat[i*DATA_WIDTH +: DATA_WIDTH] = mem[rd_ptr[i][BW-1:0]][rd_ptr[i][PW-1:BW]];
            end
            bus.pop_valid[i] = (avail > cnt_t'(i));
        end
        bus.data_pop = pop_flat;
        bus.empty    = (avail == '0);
        bus.full     = (count > CW'(CAP - CHANNEL));
    end

    // Consecutive slots land in distinct banks, so each bank takes at most one write.
    always_comb begin
        for (int b = 0; b < CHANNEL; b++) begin
            wr_slot[b] = BW'(b) - tail[BW-1:0];
            wr_row[b]  = RW'((tail + PW'(wr_slot[b])) >> BW);
            wr_en[b]   = (cnt_t'(wr_slot[b]) < push_acc);
            wr_data[b] = push_flat[wr_slot[b]*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < CHANNEL; b++) begin
            if (wr_en[b]) begin
                mem[b][wr_row[b]] <= wr_data[b];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(pop_acc);
            tail  <= tail + PW'(push_acc);
            count <= CW'(stored + push_acc - pop_acc);
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            assert (push_req <= free)
                else $warning("instr_buffer: push of %0d exceeds free space %0d, excess dropped", push_req, free);
        end
        if (pop_en) begin
            assert (pop_req <= visible)
                else $warning("instr_buffer: pop of %0d exceeds %0d valid entries, clipped", pop_req, visible);
        end
    end
endmodule

// File: tb/tb_instr_buffer.sv
// Directed bench for instr_buffer: table of single-cycle vectors plus wrap, bypass/latency and reset sequences.
module tb_instr_buffer;
    localparam int DW = 128;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_buffer_if #(.PUSH_CHANNEL(3), .POP_CHANNEL(2), .DATA_WIDTH(DW)) bus();

    instr_buffer #(
        .CHANNEL(4), .PUSH_CHANNEL(3), .POP_CHANNEL(2), .DEPTH(4), .DATA_WIDTH(DW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       fl, sp, so;
        logic [1:0] pn, on;
        int         id;
        logic [1:0] pv;
        logic       em, fu;
        int         d0, d1;
    } vec_t;

    vec_t vecs[$];
    int   n_chk = 0;
    int   n_err = 0;

    function automatic logic [DW-1:0] mk(input int n);
        return {32'(n) ^ 32'h5A5A_0000, ~32'(n), 32'(n) + 32'h1000, 32'(n)};
    endfunction

    function automatic vec_t v(input logic fl, sp, so, input logic [1:0] pn, on, input int id,
                               input logic [1:0] pv, input logic em, fu, input int d0, d1);
        vec_t r;
        r.fl = fl; r.sp = sp; r.so = so; r.pn = pn; r.on = on; r.id = id;
        r.pv = pv; r.em = em; r.fu = fu; r.d0 = d0; r.d1 = d1;
        return r;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic drive(input logic fl, sp, so, input logic [1:0] pn, on, input int id);
        bus.flush      = fl;
        bus.stall_push = sp;
        bus.stall_pop  = so;
        bus.push_num   = pn;
        bus.pop_num    = on;
        for (int s = 0; s < 3; s++) bus.data_push[s*DW +: DW] = mk(id + s);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1 idle();
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [1:0] pv, input logic em, fu, input int d0, d1);
        check({tag, ".pop_valid"}, DW'(bus.pop_valid), DW'(pv));
        check({tag, ".empty"}, DW'(bus.empty), DW'(em));
        check({tag, ".full"}, DW'(bus.full), DW'(fu));
        if (pv[0]) check({tag, ".data0"}, bus.data_pop[0 +: DW], mk(d0));
        if (pv[1]) check({tag, ".data1"}, bus.data_pop[DW +: DW], mk(d1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        //              fl sp so pn on  id    pv  em fu  d0  d1
        vecs.push_back(v(0, 0, 0, 3, 0,  1, 2'b11, 0, 0,  1,  2));
        vecs.push_back(v(0, 0, 0, 0, 2,  0, 2'b01, 0, 0,  3,  0));
        vecs.push_back(v(0, 0, 0, 2, 1,  4, 2'b11, 0, 0,  4,  5));
        vecs.push_back(v(0, 0, 1, 3, 2,  6, 2'b11, 0, 0,  4,  5));
        vecs.push_back(v(1, 0, 0, 3, 2,  9, 2'b00, 1, 0,  0,  0));
        vecs.push_back(v(0, 0, 0, 3, 0, 12, 2'b11, 0, 0, 12, 13));
        vecs.push_back(v(0, 1, 0, 3, 0, 20, 2'b11, 0, 0, 12, 13));
        vecs.push_back(v(0, 0, 0, 0, 1,  0, 2'b11, 0, 0, 13, 14));
        vecs.push_back(v(0, 0, 0, 0, 2,  0, 2'b00, 1, 0,  0,  0));
        // Fill to capacity with pops stalled; the last push finds no room.
        vecs.push_back(v(0, 0, 1, 3, 2, 30, 2'b11, 0, 0, 30, 31));
        vecs.push_back(v(0, 0, 1, 3, 0, 33, 2'b11, 0, 0, 30, 31));
        vecs.push_back(v(0, 0, 1, 3, 0, 36, 2'b11, 0, 0, 30, 31));
        vecs.push_back(v(0, 0, 1, 3, 0, 39, 2'b11, 0, 0, 30, 31));
        vecs.push_back(v(0, 0, 1, 3, 0, 42, 2'b11, 0, 1, 30, 31));
        vecs.push_back(v(0, 0, 1, 1, 0, 45, 2'b11, 0, 1, 30, 31));
        vecs.push_back(v(0, 0, 1, 3, 0, 46, 2'b11, 0, 1, 30, 31));
        // Drain across the pointer wrap; full drops once count is back to 12.
        vecs.push_back(v(0, 0, 0, 0, 2,  0, 2'b11, 0, 1, 32, 33));
        vecs.push_back(v(0, 0, 0, 0, 2,  0, 2'b11, 0, 0, 34, 35));
        vecs.push_back(v(0, 0, 0, 0, 2,  0, 2'b11, 0, 0, 36, 37));
        vecs.push_back(v(0, 0, 0, 0, 2,  0, 2'b11, 0, 0, 38, 39));
        vecs.push_back(v(0, 0, 0, 0, 2,  0, 2'b11, 0, 0, 40, 41));
        vecs.push_back(v(0, 0, 0, 0, 2,  0, 2'b11, 0, 0, 42, 43));
        vecs.push_back(v(0, 0, 0, 0, 2,  0, 2'b11, 0, 0, 44, 45));
        vecs.push_back(v(0, 0, 0, 0, 2,  0, 2'b00, 1, 0,  0,  0));
        // Over-pop of a single entry: head must move by one only.
        vecs.push_back(v(0, 0, 0, 1, 0, 60, 2'b01, 0, 0, 60,  0));
        vecs.push_back(v(0, 0, 0, 0, 2,  0, 2'b00, 1, 0,  0,  0));
        vecs.push_back(v(0, 0, 0, 2, 0, 61, 2'b11, 0, 0, 61, 62));
        vecs.push_back(v(0, 0, 0, 0, 2,  0, 2'b00, 1, 0,  0,  0));

        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2'd3, 2'd2, 200);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle();
        #1 expect_out("reset", 2'b00, 1'b1, 1'b0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].fl, vecs[i].sp, vecs[i].so, vecs[i].pn, vecs[i].on, vecs[i].id);
            step();
            expect_out($sformatf("vec%0d", i), vecs[i].pv, vecs[i].em, vecs[i].fu, vecs[i].d0, vecs[i].d1);
        end

`ifdef INSTR_BUFFER_BYPASS_EN
        drive(1'b0, 1'b0, 1'b0, 2'd3, 2'd2, 300);
        #1 expect_out("bypass_same", 2'b11, 1'b0, 1'b0, 300, 301);
        step();
        expect_out("bypass_next", 2'b01, 1'b0, 1'b0, 302, 0);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 0);
        step();
        expect_out("bypass_drain", 2'b00, 1'b1, 1'b0, 0, 0);
`else
        drive(1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 300);
        #1 expect_out("latency_same", 2'b00, 1'b1, 1'b0, 0, 0);
        step();
        expect_out("latency_next", 2'b11, 1'b0, 1'b0, 300, 301);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 0);
        step();
        expect_out("latency_pop2", 2'b01, 1'b0, 1'b0, 302, 0);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 0);
        step();
        expect_out("latency_drain", 2'b00, 1'b1, 1'b0, 0, 0);
`endif

        drive(1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 100);
        step();
        expect_out("wrap_prime", 2'b11, 1'b0, 1'b0, 100, 101);
        for (int k = 0; k < 20; k++) begin
            drive(1'b0, 1'b0, 1'b0, 2'd2, 2'd2, 102 + 2*k);
            step();
            expect_out($sformatf("wrap%0d", k), 2'b11, 1'b0, 1'b0, 102 + 2*k, 103 + 2*k);
        end
        drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 0);
        step();
        expect_out("wrap_drain", 2'b00, 1'b1, 1'b0, 0, 0);

        drive(1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 400);
        step();
        expect_out("prereset", 2'b11, 1'b0, 1'b0, 400, 401);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2'd3, 2'd1, 410);
        step();
        rst = 1'b0;
        #1 expect_out("midreset", 2'b00, 1'b1, 1'b0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/instr_buffer.md
# instr_buffer

Multi-bank instruction buffer between the I$ fetch pipeline and decode. Accepts up to PUSH_CHANNEL fetched entries per cycle and presents the oldest POP_CHANNEL entries to decode, with in-order retirement by `pop_num`. Entries are interleaved round-robin across CHANNEL single-write-port banks. `full` is a back-pressure hint; the fetch stage uses it to raise its replay logic.

## Interface
- CHANNEL, 4, number of storage banks; power of 2; must be ≥ PUSH_CHANNEL+1.
- PUSH_CHANNEL, 3, max entries pushed per cycle.
- POP_CHANNEL, 2, max entries presented/popped per cycle.
- DEPTH, 4, rows per bank; power of 2. Total capacity CAP = CHANNEL*DEPTH.
- DATA_WIDTH, 128, bits per entry.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discard all contents.
- stall_push  in  1  ignore this cycle's push.
- stall_pop  in  1  ignore this cycle's pop.
- data_push  in  PUSH_CHANNEL*DATA_WIDTH  entries; slot 0 is the oldest.
- push_num  in  $clog2(PUSH_CHANNEL+1)  number of valid slots, packed from slot 0.
- full  out  1  count > CAP−CHANNEL, i.e. at least one bank holds DEPTH entries.
- empty  out  1  count == 0.
- data_pop  out  POP_CHANNEL*DATA_WIDTH  oldest entries; slot 0 is the head.
- pop_valid  out  POP_CHANNEL  bit i = (count > i).
- pop_num  in  $clog2(POP_CHANNEL+1)  entries consumed this cycle.

## Operation
- State:
  - head and tail pointers, each $clog2(CAP) bits, wrapping naturally.
  - count, $clog2(CAP)+1 bits.
  - Storage CAP×DATA_WIDTH. Logical pointer p maps to bank p mod CHANNEL, row p / CHANNEL.
- Push (cycle without flush or stall_push):
  - Slot i < push_num is written at tail+i.
  - tail += push_num.
  - Push with full=1 is legal; upstream guarantees free space.
  - Slots beyond free space (CAP − count + popped) are dropped.
  - count saturates at CAP; a simulation assertion fires.
- Pop (cycle without flush or stall_pop):
  - head += pop_num.
  - pop_num > number of asserted pop_valid bits is clipped; an assertion fires.
- Push and pop in the same cycle:
  - Both apply.
  - count_next = count + accepted_push − accepted_pop.
  - Free space for push includes slots freed by this cycle's pop.
- Unwritten data_pop slots (pop_valid low) are don't-care. The bench compares only valid slots.
- flush or rst: head=tail=count=0. Takes priority over a same-cycle push/pop; neither is applied. Storage contents are not cleared.
- Ordering: strict FIFO; entries leave in push order across cycles and slots.

## Timing
- Reset values: full=0, empty=1, pop_valid=0, data_pop don't-care.
- data_pop, pop_valid, full and empty are combinational from registered state only. They have no path from push/pop inputs, except under the bypass option.
- Push at edge t is visible on data_pop after edge t, i.e. in cycle t+1 (1-cycle latency).
- Pop acknowledge at edge t: the next entries appear in cycle t+1.
- Wrap-around: pointers roll from CAP−1 to 0 with no bubble. A push spanning the wrap writes rows/banks modulo CAP.
- Flush asserted for one cycle: empty=1 in the following cycle. A push in the cycle after flush is accepted normally.

## Configuration
- INSTR_BUFFER_BYPASS_EN defined: when count==0, flush=0 and stall_push=0, the combinational outputs are
  - data_pop slot i = data_push slot i
  - pop_valid[i] = (push_num > i)
  - empty=0 if push_num>0

  Entries popped that cycle (pop_num, unless stall_pop) are not stored; the remainder are written from tail. This gives 0-cycle latency.
- Not defined: no input-to-output combinational path; 1-cycle latency always.

## Test plan
- Reset, then push_num=3 of A,B,C → next cycle pop_valid=2'b11, data_pop={B,A}, empty=0, full=0. pop_num=2 → next cycle data_pop[0]=C, pop_valid=2'b01.
- Fill: push 3 per cycle with stall_pop=1 → full rises when count reaches 13. Continue until count=16; a further push of 3 is dropped and the assertion fires.
- Wrap: steady push 2 / pop 2 for 20 cycles → output order matches input order exactly; count stays constant.
- Simultaneous flush+push+pop with count=5 → next cycle count=0, empty=1, pop_valid=0; the push is not retained.
- Over-pop: count=1, pop_num=2 → assertion; count=0 next cycle, head advanced by 1.
- INSTR_BUFFER_BYPASS_EN: empty queue, push_num=3 of X,Y,Z, pop_num=2 → same cycle data_pop={Y,X}, pop_valid=2'b11; next cycle data_pop[0]=Z, count=1.
